// File: rtl/ysyx_24100027_pc_seq_if.sv
// Fetch/execute handshake bundle between the PC sequencer, instruction memory and datapath.
// master = sequencer side, slave = memory/datapath side.
interface ysyx_24100027_pc_seq_if;
    logic        ifu_req_valid;
    logic        ifu_req_ready;
    logic [31:0] ifu_addr;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_q;
    logic        exu_valid;
    logic        exu_done;
    logic        PCActr;
    logic        PCBctr;
    logic [31:0] imm;
    logic [31:0] rs1;
    logic [31:0] pc;
    logic        retire;
    logic [31:0] instret;
    logic        trap;

    modport master (
        output ifu_req_valid, ifu_addr, inst_q, exu_valid, pc, retire, instret, trap,
        input  ifu_req_ready, inst_valid, inst, exu_done, PCActr, PCBctr, imm, rs1
    );

    modport slave (
        input  ifu_req_valid, ifu_addr, inst_q, exu_valid, pc, retire, instret, trap,
        output ifu_req_ready, inst_valid, inst, exu_done, PCActr, PCBctr, imm, rs1
    );
endinterface

// File: rtl/ysyx_24100027_pc_seq.sv
// Multi-cycle PC sequencer: fetch request, fetch wait, execute, with branch/jalr next-PC.
// Optional misaligned-target trap enabled by defining YSYX_24100027_PC_SEQ_MISALIGN_TRAP_EN.
module ysyx_24100027_pc_seq #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic                          clk,
    input  logic                          rst,
    ysyx_24100027_pc_seq_if.master        bus
);

    localparam logic [3:0] FETCH_REQ  = 4'b0001;
    localparam logic [3:0] FETCH_WAIT = 4'b0010;
    localparam logic [3:0] EXEC       = 4'b0100;
    localparam logic [3:0] TRAP       = 4'b1000;

    logic [3:0]  state_q,   state_d;
    logic [31:0] pc_q,      pc_d;
    logic [31:0] ir_q,      ir_d;
    logic        retire_q,  retire_d;
    logic [31:0] instret_q, instret_d;

    logic [31:0] next_pc_base;
    logic [31:0] next_pc_off;
    logic [31:0] next_pc;

`ifdef YSYX_24100027_PC_SEQ_MISALIGN_TRAP_EN
    logic        trap_q, trap_d;
    logic        misaligned;
`endif

    // Target address: base + offset, wrapping mod 2^32.
    always_comb begin
        next_pc_base = bus.PCBctr ? bus.rs1 : pc_q;
        next_pc_off  = bus.PCActr ? bus.imm : 32'd4;
        next_pc      = next_pc_base + next_pc_off;
        if (bus.PCBctr) begin
            next_pc[0] = 1'b0;
        end
`ifdef YSYX_24100027_PC_SEQ_MISALIGN_TRAP_EN
        misaligned   = next_pc[1];
`else
        next_pc[1:0] = 2'b00;
`endif
    end

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        retire_d  = 1'b0;
        instret_d = instret_q;
`ifdef YSYX_24100027_PC_SEQ_MISALIGN_TRAP_EN
        trap_d    = trap_q;
`endif

        case (state_q)
            FETCH_REQ: begin
                if (bus.ifu_req_ready) begin
                    state_d = FETCH_WAIT;
                end
            end

            FETCH_WAIT: begin
                if (bus.inst_valid) begin
                    ir_d    = bus.inst;
                    state_d = EXEC;
                end
            end

            EXEC: begin
                if (bus.exu_done) begin
`ifdef YSYX_24100027_PC_SEQ_MISALIGN_TRAP_EN
                    if (misaligned) begin
                        trap_d  = 1'b1;
                        state_d = TRAP;
                    end else begin
                        pc_d      = next_pc;
                        retire_d  = 1'b1;
                        instret_d = instret_q + 32'd1;
                        state_d   = FETCH_REQ;
                    end
`else
                    pc_d      = next_pc;
                    retire_d  = 1'b1;
                    instret_d = instret_q + 32'd1;
                    state_d   = FETCH_REQ;
`endif
                end
            end

`ifdef YSYX_24100027_PC_SEQ_MISALIGN_TRAP_EN
            // Sticky until reset: everything stays frozen.
            TRAP: begin
                state_d = TRAP;
            end
`endif

            default: begin
                state_d = FETCH_REQ;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= FETCH_REQ;
            pc_q      <= RESET_PC;
            ir_q      <= 32'd0;
            retire_q  <= 1'b0;
            instret_q <= 32'd0;
`ifdef YSYX_24100027_PC_SEQ_MISALIGN_TRAP_EN
            trap_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            retire_q  <= retire_d;
            instret_q <= instret_d;
`ifdef YSYX_24100027_PC_SEQ_MISALIGN_TRAP_EN
            trap_q    <= trap_d;
`endif
        end
    end

    // Handshake valids come straight from state so they are glitch-free after reset.
    assign bus.ifu_req_valid = (state_q == FETCH_REQ);
    assign bus.exu_valid     = (state_q == EXEC);
    assign bus.ifu_addr      = pc_q;
    assign bus.pc            = pc_q;
    assign bus.inst_q        = ir_q;
    assign bus.retire        = retire_q;
    assign bus.instret       = instret_q;
`ifdef YSYX_24100027_PC_SEQ_MISALIGN_TRAP_EN
    assign bus.trap          = trap_q;
`else
    assign bus.trap          = 1'b0;
`endif

endmodule

// File: tb/tb_ysyx_24100027_pc_seq.sv
// Self-checking bench for ysyx_24100027_pc_seq: retire scoreboard plus direct handshake checks.
module tb_ysyx_24100027_pc_seq;

    localparam logic [31:0] RESET_PC = 32'h8000_0000;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instret;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ysyx_24100027_pc_seq_if bus ();

    ysyx_24100027_pc_seq #(.RESET_PC(RESET_PC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] m_pc;
    logic [31:0] m_instret;
    logic        prev_retire = 1'b0;
    int          cyc = 0;
    int          last_retire_cyc = 0;
    int          retire_gap = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] calc_next(input logic [31:0] cur_pc, input logic [31:0] imm,
                                              input logic [31:0] rs1, input logic pca, input logic pcb);
        logic [31:0] n;
        n = (pcb ? rs1 : cur_pc) + (pca ? imm : 32'd4);
        if (pcb) n[0] = 1'b0;
`ifndef YSYX_24100027_PC_SEQ_MISALIGN_TRAP_EN
        n[1:0] = 2'b00;
`endif
        return n;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Retire monitor: each pulse must match the oldest scoreboard entry.
    always @(negedge clk) begin
        exp_t e;
        if (bus.retire === 1'b1) begin
            check("retire_width", {31'd0, prev_retire}, 32'd0);
            retire_gap      <= cyc - last_retire_cyc;
            last_retire_cyc <= cyc;
            if (sb.size() == 0) begin
                check("retire_unexpected", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("sb_pc", bus.pc, e.pc);
                check("sb_instret", bus.instret, e.instret);
            end
        end
        prev_retire <= bus.retire;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Runs one full fetch/execute; starts and ends 1 time unit after a rising edge.
    task automatic do_instr(input logic [31:0] word, input logic pca, input logic pcb,
                            input logic [31:0] imm, input logic [31:0] rs1,
                            input int ready_stall, input int exec_stall);
        logic [31:0] addr0;
        logic [31:0] ir_prev;
        logic [31:0] nxt;
        logic        trap_exp;
        check("fetch_req_valid", {31'd0, bus.ifu_req_valid}, 32'd1);
        check("ifu_addr_eq_pc", bus.ifu_addr, m_pc);
        addr0   = bus.ifu_addr;
        ir_prev = bus.inst_q;
        for (int i = 0; i < ready_stall; i++) begin
            bus.ifu_req_ready = 1'b0;
            bus.exu_done      = 1'b1;
            tick();
            check("stall_addr", bus.ifu_addr, addr0);
            check("stall_req", {31'd0, bus.ifu_req_valid}, 32'd1);
        end
        bus.exu_done      = 1'b0;
        bus.ifu_req_ready = 1'b1;
        bus.inst_valid    = 1'b1;
        bus.inst          = 32'hDEAD_BEEF;
        tick();
        bus.ifu_req_ready = 1'b0;
        check("wait_no_req", {31'd0, bus.ifu_req_valid}, 32'd0);
        check("ir_ignore_in_req", bus.inst_q, ir_prev);
        bus.inst = word;
        tick();
        bus.inst_valid = 1'b0;
        check("exec_valid", {31'd0, bus.exu_valid}, 32'd1);
        check("inst_q", bus.inst_q, word);
        for (int i = 0; i < exec_stall; i++) begin
            bus.inst_valid = 1'b1;
            bus.inst       = ~word;
            tick();
            check("exec_ir_hold", bus.inst_q, word);
            check("exec_no_retire", {31'd0, bus.retire}, 32'd0);
        end
        bus.inst_valid = 1'b0;
        bus.PCActr     = pca;
        bus.PCBctr     = pcb;
        bus.imm        = imm;
        bus.rs1        = rs1;
        bus.exu_done   = 1'b1;
        nxt            = calc_next(m_pc, imm, rs1, pca, pcb);
        trap_exp       = 1'b0;
`ifdef YSYX_24100027_PC_SEQ_MISALIGN_TRAP_EN
        trap_exp       = nxt[1];
`endif
        if (!trap_exp) begin
            m_pc      = nxt;
            m_instret = m_instret + 32'd1;
            sb.push_back('{nxt, m_instret});
        end
        tick();
        bus.exu_done = 1'b0;
        bus.PCActr   = 1'b0;
        bus.PCBctr   = 1'b0;
`ifdef YSYX_24100027_PC_SEQ_MISALIGN_TRAP_EN
        if (trap_exp) begin
            check("trap_flag", {31'd0, bus.trap}, 32'd1);
            check("trap_pc_hold", bus.pc, m_pc);
            check("trap_no_req", {31'd0, bus.ifu_req_valid}, 32'd0);
            check("trap_no_retire", {31'd0, bus.retire}, 32'd0);
        end else
`endif
        begin
            check("retire_pulse", {31'd0, bus.retire}, 32'd1);
            check("back_to_fetch", {31'd0, bus.ifu_req_valid}, 32'd1);
            check("exu_valid_clr", {31'd0, bus.exu_valid}, 32'd0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst               = 1'b1;
        bus.ifu_req_ready = 1'b0;
        bus.inst_valid    = 1'b0;
        bus.inst          = 32'd0;
        bus.exu_done      = 1'b0;
        bus.PCActr        = 1'b0;
        bus.PCBctr        = 1'b0;
        bus.imm           = 32'd0;
        bus.rs1           = 32'd0;
        tick();
        tick();
        rst       = 1'b0;
        m_pc      = RESET_PC;
        m_instret = 32'd0;

        check("rst_pc", bus.pc, 32'h8000_0000);
        check("rst_addr", bus.ifu_addr, 32'h8000_0000);
        check("rst_req_valid", {31'd0, bus.ifu_req_valid}, 32'd1);
        check("rst_exu_valid", {31'd0, bus.exu_valid}, 32'd0);
        check("rst_retire", {31'd0, bus.retire}, 32'd0);
        check("rst_instret", bus.instret, 32'd0);
        check("rst_trap", {31'd0, bus.trap}, 32'd0);
        check("rst_inst_q", bus.inst_q, 32'd0);

        // Back-to-back sequential instructions.
        do_instr(32'h0000_0013, 1'b0, 1'b0, 32'd0, 32'd0, 0, 0);
        do_instr(32'h0010_0093, 1'b0, 1'b0, 32'd0, 32'd0, 0, 0);
        check("seq_pc", bus.pc, 32'h8000_0008);
        check("seq_instret", bus.instret, 32'd2);
        @(negedge clk);
        #1;
        check("retire_gap", retire_gap, 32'd3);
        tick();

        do_instr(32'h0020_0113, 1'b0, 1'b0, 32'd0, 32'd0, 0, 0);
        do_instr(32'h0030_0193, 1'b0, 1'b0, 32'd0, 32'd0, 0, 0);
        check("pre_branch_pc", bus.pc, 32'h8000_0010);

        do_instr(32'hFE00_0CE3, 1'b1, 1'b0, 32'hFFFF_FFF8, 32'h1234_5678, 0, 0);
        check("branch_pc", bus.pc, 32'h8000_0008);

        do_instr(32'h0040_8067, 1'b1, 1'b1, 32'd4, 32'h8000_1001, 0, 0);
        check("jalr_pc", bus.pc, 32'h8000_1004);

        do_instr(32'h0050_0213, 1'b0, 1'b0, 32'd0, 32'd0, 5, 4);
        check("stall_pc", bus.pc, 32'h8000_1008);

        do_instr(32'h0000_8067, 1'b0, 1'b1, 32'd0, 32'hFFFF_FFFC, 0, 0);
        check("wrap_pc", bus.pc, 32'h0000_0000);

        do_instr(32'h0020_8067, 1'b1, 1'b1, 32'd2, 32'h8000_0000, 0, 0);
`ifdef YSYX_24100027_PC_SEQ_MISALIGN_TRAP_EN
        check("misalign_pc", bus.pc, 32'h0000_0000);
        bus.ifu_req_ready = 1'b1;
        bus.inst_valid    = 1'b1;
        bus.exu_done      = 1'b1;
        tick();
        tick();
        bus.ifu_req_ready = 1'b0;
        bus.inst_valid    = 1'b0;
        bus.exu_done      = 1'b0;
        check("trap_sticky", {31'd0, bus.trap}, 32'd1);
        check("trap_sticky_pc", bus.pc, 32'h0000_0000);
        rst = 1'b1;
        tick();
        rst       = 1'b0;
        m_pc      = RESET_PC;
        m_instret = 32'd0;
`else
        check("misalign_pc", bus.pc, 32'h8000_0000);
`endif

        // Reset while executing, with exu_done arriving in the same and the next cycle.
        bus.ifu_req_ready = 1'b1;
        tick();
        bus.ifu_req_ready = 1'b0;
        bus.inst_valid    = 1'b1;
        bus.inst          = 32'h0000_0073;
        tick();
        bus.inst_valid    = 1'b0;
        check("pre_rst_exec", {31'd0, bus.exu_valid}, 32'd1);
        rst          = 1'b1;
        bus.exu_done = 1'b1;
        bus.PCActr   = 1'b1;
        bus.imm      = 32'h0000_0100;
        tick();
        rst = 1'b0;
        check("rst_exec_pc", bus.pc, 32'h8000_0000);
        check("rst_exec_retire", {31'd0, bus.retire}, 32'd0);
        check("rst_exec_instret", bus.instret, 32'd0);
        check("rst_exec_req", {31'd0, bus.ifu_req_valid}, 32'd1);
        check("rst_exec_exu", {31'd0, bus.exu_valid}, 32'd0);
        check("rst_exec_inst_q", bus.inst_q, 32'd0);
        tick();
        bus.exu_done = 1'b0;
        bus.PCActr   = 1'b0;
        check("late_done_pc", bus.pc, 32'h8000_0000);
        check("late_done_retire", {31'd0, bus.retire}, 32'd0);
        m_pc      = RESET_PC;
        m_instret = 32'd0;

        // Reset while waiting for the fetch; late inst_valid must be ignored.
        bus.ifu_req_ready = 1'b1;
        tick();
        bus.ifu_req_ready = 1'b0;
        rst = 1'b1;
        tick();
        rst            = 1'b0;
        bus.inst_valid = 1'b1;
        bus.inst       = 32'hCAFE_F00D;
        tick();
        bus.inst_valid = 1'b0;
        check("late_inst_exu", {31'd0, bus.exu_valid}, 32'd0);
        check("late_inst_q", bus.inst_q, 32'd0);
        check("late_inst_req", {31'd0, bus.ifu_req_valid}, 32'd1);

        do_instr(32'h0000_0013, 1'b0, 1'b0, 32'd0, 32'd0, 0, 0);
        check("post_rst_pc", bus.pc, 32'h8000_0004);
        check("post_rst_instret", bus.instret, 32'd1);

        tick();
        tick();
        check("sb_drain", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
